// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// master = sequencer, slave = datapath / memory side.
interface multicycle_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        z;
  logic        mem_ready;
  logic        Wpc;
  logic        Wir;
  logic        Wreg;
  logic        Wmem;
  logic        Regrt;
  logic        Se;
  logic        Aluqb;
  logic [1:0]  Aluc;
  logic [1:0]  Pcsrc;
  logic        Reg2reg;
  logic        Reglui;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired;

  modport master (
    input  op, func, z, mem_ready,
    output Wpc, Wir, Wreg, Wmem,
    output Regrt, Se, Aluqb, Aluc,
    output Pcsrc, Reg2reg, Reglui,
    output state, illegal, retired
  );

  modport slave (
    output op, func, z, mem_ready,
    input  Wpc, Wir, Wreg, Wmem,
    input  Regrt, Se, Aluqb, Aluc,
    input  Pcsrc, Reg2reg, Reglui,
    input  state, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: IF/ID/EX/MEM/WB FSM
// with data-memory wait states and a retired counter.
module multicycle_ctrl (
  input  logic clk,
  input  logic pcrst,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t cur, nxt;

  logic rtype, r_add, r_sub, r_and, r_or;
  logic i_addi, i_andi, i_ori, i_lui;
  logic i_lw, i_sw, i_beq, i_bne, i_j;
  logic legal, itype, branch, taken;
  logic wpc, wir, wreg, wmem, ill;
  logic [1:0] pcsrc;

  // Instruction decode from the IR fields.
  always_comb begin
    rtype  = (bus.op == 6'b000000);
    r_add  = rtype && (bus.func == 6'b100000);
    r_sub  = rtype && (bus.func == 6'b100010);
    r_and  = rtype && (bus.func == 6'b100100);
    r_or   = rtype && (bus.func == 6'b100101);
    i_addi = (bus.op == 6'b001000);
    i_andi = (bus.op == 6'b001100);
    i_ori  = (bus.op == 6'b001101);
    i_lui  = (bus.op == 6'b001111);
    i_lw   = (bus.op == 6'b100011);
    i_sw   = (bus.op == 6'b101011);
    i_beq  = (bus.op == 6'b000100);
    i_bne  = (bus.op == 6'b000101);
    i_j    = (bus.op == 6'b000010);
    itype  = i_addi | i_andi | i_ori | i_lui
           | i_lw | i_sw | i_beq | i_bne;
    legal  = r_add | r_sub | r_and | r_or
           | itype | i_j;
    branch = i_beq | i_bne;
    taken  = (i_beq & bus.z) | (i_bne & ~bus.z);
  end

  // State register; reset returns to fetch.
  always_ff @(posedge clk) begin
    if (pcrst) cur <= S_IF;
    else       cur <= nxt;
  end

  // Next state and sequencing strobes.
  always_comb begin
    nxt   = cur;
    wpc   = 1'b0;
    wir   = 1'b0;
    wreg  = 1'b0;
    wmem  = 1'b0;
    ill   = 1'b0;
    pcsrc = 2'b00;
    unique case (cur)
      S_IF: begin
        wir = 1'b1;
        nxt = S_ID;
      end
      S_ID: begin
        if (i_lui) begin
          nxt = S_WB;
        end else if (i_j) begin
          wpc   = 1'b1;
          pcsrc = 2'b11;
          nxt   = S_IF;
        end else if (!legal) begin
          wpc = 1'b1;
          ill = 1'b1;
          nxt = S_IF;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        if (branch) begin
          wpc   = 1'b1;
          pcsrc = taken ? 2'b10 : 2'b00;
          nxt   = S_IF;
        end else if (i_lw | i_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        wmem = i_sw;
        if (bus.mem_ready) begin
          if (i_sw) begin
            wpc = 1'b1;
            nxt = S_IF;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        wreg = 1'b1;
        wpc  = 1'b1;
        nxt  = S_IF;
      end
      default: nxt = S_IF;
    endcase
    if (pcrst) begin
      wpc  = 1'b0;
      wir  = 1'b0;
      wreg = 1'b0;
      wmem = 1'b0;
      ill  = 1'b0;
    end
  end

  // Datapath selects, held at 0 in fetch and for undefined opcodes.
  always_comb begin
    bus.Regrt   = 1'b0;
    bus.Se      = 1'b0;
    bus.Aluqb   = 1'b0;
    bus.Aluc    = 2'b00;
    bus.Reg2reg = 1'b0;
    bus.Reglui  = 1'b0;
    if (cur != S_IF && legal) begin
      bus.Regrt   = itype;
      bus.Se      = i_addi | i_lw | i_sw | branch;
      bus.Aluqb   = rtype | branch;
      bus.Reg2reg = ~i_lw;
      bus.Reglui  = i_lui;
      unique case (1'b1)
        r_sub | branch:  bus.Aluc = 2'b01;
        r_and | i_andi:  bus.Aluc = 2'b10;
        r_or  | i_ori:   bus.Aluc = 2'b11;
        default:         bus.Aluc = 2'b00;
      endcase
    end
  end

  // Count instructions that complete without a decode fault.
  always_ff @(posedge clk) begin
    if (pcrst)           bus.retired <= 32'd0;
    else if (wpc && !ill) bus.retired <= bus.retired + 32'd1;
  end

  assign bus.Wpc     = wpc;
  assign bus.Wir     = wir;
  assign bus.Wreg    = wreg;
  assign bus.Wmem    = wmem;
  assign bus.illegal = ill;
  assign bus.Pcsrc   = pcsrc;
  assign bus.state   = cur;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected
// strobes are queued per instruction and checked cycle by cycle.
module tb_multicycle_ctrl;
  logic clk;
  logic pcrst;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .pcrst (pcrst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] st;
    logic       wpc;
    logic       wreg;
    logic       wmem;
    logic [1:0] pcs;
    logic       ill;
    logic       mr;
    logic       z;
    logic [5:0] op;
    logic [5:0] func;
  } ent_t;

  ent_t q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_ret = 0;
  logic [5:0] c_op, c_func;
  logic c_z;

  localparam int C_ALU = 0, C_LUI = 1, C_J = 2, C_BR = 3;
  localparam int C_LW = 4, C_SW = 5, C_ILL = 6;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int cls(input logic [5:0] op,
                             input logic [5:0] fn);
    case (op)
      6'b000000:
        if (fn inside {6'b100000, 6'b100010,
                       6'b100100, 6'b100101})
          return C_ALU;
        else
          return C_ILL;
      6'b001000, 6'b001100, 6'b001101: return C_ALU;
      6'b001111: return C_LUI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100, 6'b000101: return C_BR;
      6'b000010: return C_J;
      default: return C_ILL;
    endcase
  endfunction

  // {Regrt, Se, Aluqb, Aluc[1:0], Reg2reg, Reglui}
  function automatic logic [6:0] dpx(input logic [5:0] op,
                                     input logic [5:0] fn,
                                     input logic [2:0] st);
    logic rg, se, qb, r2, lu;
    logic [1:0] ac;
    if (st == 3'd0 || cls(op, fn) == C_ILL) return 7'd0;
    rg = op inside {6'b001000, 6'b001100, 6'b001101,
                    6'b001111, 6'b100011, 6'b101011,
                    6'b000100, 6'b000101};
    se = op inside {6'b001000, 6'b100011, 6'b101011,
                    6'b000100, 6'b000101};
    qb = op inside {6'b000000, 6'b000100, 6'b000101};
    r2 = (op != 6'b100011);
    lu = (op == 6'b001111);
    ac = 2'b00;
    if ((op == 0 && fn == 6'b100010) ||
        op == 6'b000100 || op == 6'b000101) ac = 2'b01;
    if ((op == 0 && fn == 6'b100100) ||
        op == 6'b001100) ac = 2'b10;
    if ((op == 0 && fn == 6'b100101) ||
        op == 6'b001101) ac = 2'b11;
    return {rg, se, qb, ac, r2, lu};
  endfunction

  task automatic push(input logic [2:0] st, input logic wpc,
                      input logic wreg, input logic wmem,
                      input logic [1:0] pcs, input logic ill,
                      input logic mr);
    ent_t e;
    e.st = st; e.wpc = wpc; e.wreg = wreg; e.wmem = wmem;
    e.pcs = pcs; e.ill = ill; e.mr = mr;
    e.z = c_z; e.op = c_op; e.func = c_func;
    q.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle trace of one instruction.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int w);
    logic tk;
    c_op = op; c_func = fn; c_z = z;
    tk = (op == 6'b000100) ? z : ~z;
    push(3'd0, 0, 0, 0, 2'b00, 0, rnd());
    case (cls(op, fn))
      C_LUI: begin
        push(3'd1, 0, 0, 0, 2'b00, 0, rnd());
        push(3'd4, 1, 1, 0, 2'b00, 0, rnd());
      end
      C_J:   push(3'd1, 1, 0, 0, 2'b11, 0, rnd());
      C_ILL: push(3'd1, 1, 0, 0, 2'b00, 1, rnd());
      C_BR: begin
        push(3'd1, 0, 0, 0, 2'b00, 0, rnd());
        push(3'd2, 1, 0, 0, tk ? 2'b10 : 2'b00, 0, rnd());
      end
      C_ALU: begin
        push(3'd1, 0, 0, 0, 2'b00, 0, rnd());
        push(3'd2, 0, 0, 0, 2'b00, 0, rnd());
        push(3'd4, 1, 1, 0, 2'b00, 0, rnd());
      end
      C_SW: begin
        push(3'd1, 0, 0, 0, 2'b00, 0, rnd());
        push(3'd2, 0, 0, 0, 2'b00, 0, rnd());
        for (int i = 0; i < w; i++)
          push(3'd3, 0, 0, 1, 2'b00, 0, 1'b0);
        push(3'd3, 1, 0, 1, 2'b00, 0, 1'b1);
      end
      default: begin
        push(3'd1, 0, 0, 0, 2'b00, 0, rnd());
        push(3'd2, 0, 0, 0, 2'b00, 0, rnd());
        for (int i = 0; i < w; i++)
          push(3'd3, 0, 0, 0, 2'b00, 0, 1'b0);
        push(3'd3, 0, 0, 0, 2'b00, 0, 1'b1);
        push(3'd4, 1, 1, 0, 2'b00, 0, rnd());
      end
    endcase
  endtask

  // Apply and check queued cycles; entered in the low phase.
  task automatic drain();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      pcrst = 1'b0;
      bus.op = e.op;
      bus.func = e.func;
      bus.z = e.z;
      bus.mem_ready = e.mr;
      #1;
      chk("state", 32'(bus.state), 32'(e.st));
      chk("Wpc", 32'(bus.Wpc), 32'(e.wpc));
      chk("Wir", 32'(bus.Wir), 32'(e.st == 3'd0));
      chk("Wreg", 32'(bus.Wreg), 32'(e.wreg));
      chk("Wmem", 32'(bus.Wmem), 32'(e.wmem));
      chk("Pcsrc", 32'(bus.Pcsrc), 32'(e.pcs));
      chk("illegal", 32'(bus.illegal), 32'(e.ill));
      chk("dpctl",
          32'({bus.Regrt, bus.Se, bus.Aluqb, bus.Aluc,
               bus.Reg2reg, bus.Reglui}),
          32'(dpx(e.op, e.func, e.st)));
      chk("retired", bus.retired, exp_ret);
      if (e.wpc && !e.ill) exp_ret = exp_ret + 1;
      @(negedge clk);
    end
  endtask

  initial begin
    pcrst = 1'b1;
    bus.op = 6'd0;
    bus.func = 6'd0;
    bus.z = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    chk("rst_Wpc", 32'(bus.Wpc), 32'd0);
    chk("rst_Wir", 32'(bus.Wir), 32'd0);
    exp_ret = 0;

    instr(6'b000000, 6'b100000, 1'b0, 0);
    instr(6'b100011, 6'b000000, 1'b0, 3);
    instr(6'b101011, 6'b000000, 1'b0, 0);
    instr(6'b000100, 6'b000000, 1'b1, 0);
    instr(6'b000101, 6'b000000, 1'b1, 0);
    instr(6'b000010, 6'b000000, 1'b0, 0);
    instr(6'b111111, 6'b000000, 1'b0, 0);
    instr(6'b000000, 6'b000000, 1'b0, 0);
    instr(6'b000000, 6'b100010, 1'b0, 0);
    instr(6'b000000, 6'b100100, 1'b1, 0);
    instr(6'b000000, 6'b100101, 1'b0, 0);
    instr(6'b001000, 6'b010101, 1'b0, 0);
    instr(6'b001100, 6'b000000, 1'b1, 0);
    instr(6'b001101, 6'b000000, 1'b0, 0);
    instr(6'b001111, 6'b000000, 1'b0, 0);
    instr(6'b000101, 6'b000000, 1'b0, 0);
    instr(6'b000100, 6'b000000, 1'b0, 0);
    instr(6'b101011, 6'b000000, 1'b0, 2);
    instr(6'b100011, 6'b000000, 1'b0, 0);
    drain();

    // lw stalled in MEM, then reset held for two cycles.
    c_op = 6'b100011; c_func = 6'd0; c_z = 1'b0;
    push(3'd0, 0, 0, 0, 2'b00, 0, 1'b1);
    push(3'd1, 0, 0, 0, 2'b00, 0, 1'b1);
    push(3'd2, 0, 0, 0, 2'b00, 0, 1'b1);
    push(3'd3, 0, 0, 0, 2'b00, 0, 1'b0);
    drain();
    bus.mem_ready = 1'b0;
    pcrst = 1'b1;
    #1;
    chk("mrst_state", 32'(bus.state), 32'd3);
    chk("mrst_Wmem", 32'(bus.Wmem), 32'd0);
    chk("mrst_Wpc", 32'(bus.Wpc), 32'd0);
    chk("mrst_Wreg", 32'(bus.Wreg), 32'd0);
    @(negedge clk);
    #1;
    chk("mrst2_state", 32'(bus.state), 32'd0);
    chk("mrst2_retired", bus.retired, 32'd0);
    chk("mrst2_Wir", 32'(bus.Wir), 32'd0);
    chk("mrst2_Wmem", 32'(bus.Wmem), 32'd0);
    @(negedge clk);
    pcrst = 1'b0;
    #1;
    chk("post_state", 32'(bus.state), 32'd0);
    chk("post_Wir", 32'(bus.Wir), 32'd1);
    exp_ret = 0;
    instr(6'b000000, 6'b100000, 1'b0, 0);
    instr(6'b101011, 6'b000000, 1'b0, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer for the CPU datapath. It replaces single-cycle control with a five-state FSM that splits each instruction into fetch, decode, execute, memory and write-back steps. It drives the same datapath controls as the single-cycle control unit, adds PC and instruction-register write enables, and handshakes with a data memory that may need wait states. It sits beside the register file and ALU and takes op, func and z from the IR and ALU.

## Interface
- No parameters. Opcodes and state encoding are fixed.
- clk  in  1  system clock; all state changes on the rising edge.
- pcrst  in  1  reset, synchronous, active-high.
- op  in  6  IR[31:26]; stable from the ID state until the next IF.
- func  in  6  IR[5:0].
- z  in  1  ALU zero flag.
- mem_ready  in  1  data memory has completed the current access.
- Wpc  out  1  PC load enable.
- Wir  out  1  IR load enable.
- Wreg  out  1  register file write enable.
- Wmem  out  1  data memory write request.
- Regrt  out  1  1 selects rt as the write register, 0 selects rd.
- Se  out  1  1 sign-extends imm16, 0 zero-extends.
- Aluqb  out  1  1 selects qb as the ALU B operand, 0 selects extimme.
- Aluc  out  2  00 add, 01 sub, 10 and, 11 or.
- Pcsrc  out  2  00 pc+4, 10 branch target, 11 jump target. 01 is never driven.
- Reg2reg  out  1  1 selects the ALU result for write-back, 0 selects memory data.
- Reglui  out  1  1 selects {imm16,16'b0} for write-back.
- state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded.
- retired  out  32  count of completed legal instructions.

## Operation
- Decoded instructions:
  - R-type (op 000000) with func add 100000, sub 100010, and 100100, or 100101.
  - addi 001000, andi 001100, ori 001101, lui 001111.
  - lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
  - An R-type with any other func, or any other op, is illegal.
- Datapath controls are combinational from state, op and func. Outside their active states they are 0.
  - Regrt=1 for all I-type instructions.
  - Se=1 for addi, lw, sw, beq, bne.
  - Aluqb=1 for R-type, beq, bne.
  - Aluc=01 for sub, beq, bne.
  - Reg2reg=0 only for lw.
  - Reglui=1 only for lui.
- State transitions:
  - IF: Wir=1. Go to ID.
  - ID, lui: go to WB.
  - ID, j: Wpc=1, Pcsrc=11, go to IF.
  - ID, illegal: Wpc=1, Pcsrc=00, illegal=1, go to IF.
  - ID, all others: go to EX.
  - EX, beq/bne: Wpc=1. Pcsrc=10 if taken (beq: z=1; bne: z=0), else 00. Go to IF.
  - EX, lw/sw: go to MEM.
  - EX, ALU instructions: go to WB.
  - MEM, sw: Wmem=1 for the whole time in MEM. When mem_ready=1: Wpc=1, Pcsrc=00, go to IF.
  - MEM, lw: stay until mem_ready=1, then go to WB.
  - WB: Wreg=1, Wpc=1, Pcsrc=00. Go to IF.
- retired increments by 1 in every cycle where Wpc=1 and illegal=0. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - While pcrst=1, Wpc, Wir, Wreg, Wmem and illegal are forced to 0 in that same cycle.
  - The edge with pcrst=1 sets state=IF and retired=0.
  - pcrst overrides everything, including an in-progress MEM wait; the pending Wmem drops immediately.
- Cycles per instruction with mem_ready already high:
  - j: 2. Illegal: 2. lui: 3. beq/bne: 3.
  - R-type, addi, andi, ori: 4. sw: 4. lw: 5.
  - Each cycle of mem_ready=0 in MEM adds one cycle.
- mem_ready is sampled only in MEM; it is ignored in every other state.
- Wpc asserts in exactly one cycle per instruction: the last one before IF.
- Wreg asserts only in WB. Wir asserts only in IF.

## Test plan
- Reset: hold pcrst=1 for 2 cycles in the middle of a lw MEM wait -> state=0, retired=0, and Wmem/Wreg/Wpc all 0 while pcrst=1; the next cycle is IF with Wir=1.
- add (op 000000, func 100000) -> states 0,1,2,4. In WB: Wreg=1, Regrt=0, Aluqb=1, Aluc=00, Reg2reg=1, Wpc=1, Pcsrc=00. retired goes 0 to 1.
- lw with mem_ready low for 3 cycles -> states 0,1,2,3,3,3,3,4 (4 cycles in MEM). Wreg=1 only in WB, with Reg2reg=0, Se=1, Aluqb=0. Total 8 cycles.
- sw with mem_ready=1 -> Wmem=1 for exactly one cycle (state 3); Wpc=1 in that same cycle; Wreg never asserts.
- beq with z=1, then bne with z=1 -> first: EX has Pcsrc=10, Aluc=01, Wpc=1. Second: EX has Pcsrc=00. Each instruction takes 3 cycles.
- j, then op 111111, then R-type func 000000 -> j: Pcsrc=11 in ID, 2 cycles. Both illegal words: illegal pulses once each, retired does not increment for them.
